// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - address map, access codes and lane helper for the data bus
package data_bus_pkg;

  localparam logic [11:0] ADDR_IO_IN  = 12'h400;
  localparam logic [11:0] ADDR_IO_OUT = 12'h404;
  localparam logic [11:0] ADDR_CYCLE  = 12'h408;
  localparam logic [11:0] RAM_TOP     = 12'h3FF;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_IO_IN,
    REG_IO_OUT,
    REG_CYCLE
  } region_e;

  // Undefined access codes fall into the word case.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// rtl/byte_lane_ram.sv - word-wide RAM with byte-enable write and registered read
module byte_lane_ram #(
  parameter int WORDS = 256
) (
  input  logic                       clock,
  input  logic [$clog2(WORDS)-1:0]   addr,
  input  logic [3:0]                 be,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_bus_unit.sv
// rtl/data_bus_unit.sv - MEM-stage data bus: RAM, MMIO ports and cycle counter
module data_bus_unit
  import data_bus_pkg::*;
#(
  parameter int RAM_WORDS   = 256,
  parameter int IO_WIDTH    = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         addr,
  input  logic [31:0]         wdata,
  input  logic [2:0]          funct3,
  input  logic                rd_en,
  input  logic                wr_en,
  output logic [31:0]         rdata,
  output logic                misaligned,
  input  logic [IO_WIDTH-1:0] io_input_bus,
  output logic [IO_WIDTH-1:0] io_output_bus
);

  localparam int AW = $clog2(RAM_WORDS);

  region_e              region;
  logic                 misalign_raw;
  logic                 store_ok;
  logic                 load_ok;
  logic [3:0]           be;
  logic [31:0]          wdata_lanes;
  logic [IO_WIDTH-1:0]  io_next;
  logic [31:0]          mmio_word;
  logic [31:0]          cycle_cnt;
  logic [IO_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [31:0]          ram_rdata;

  logic                 load_q;
  logic                 ram_sel_q;
  logic [1:0]           off_q;
  logic [2:0]           f3_q;
  logic [31:0]          mmio_q;

  always_comb begin
    region = REG_NONE;
    if (addr <= RAM_TOP)                         region = REG_RAM;
    else if (addr[11:2] == ADDR_IO_IN[11:2])     region = REG_IO_IN;
    else if (addr[11:2] == ADDR_IO_OUT[11:2])    region = REG_IO_OUT;
    else if (addr[11:2] == ADDR_CYCLE[11:2])     region = REG_CYCLE;
  end

  always_comb begin
    misalign_raw = 1'b0;
    case (funct3[1:0])
      2'b00:   misalign_raw = 1'b0;
      2'b01:   misalign_raw = addr[0];
      default: misalign_raw = (addr[1:0] != 2'b00);
    endcase
  end

  // A simultaneous rd_en/wr_en is a store; reset suppresses every write.
  assign store_ok = wr_en && !misalign_raw && !reset;
  assign load_ok  = rd_en && !wr_en && !misalign_raw;
  assign be       = byte_enable(funct3, addr[1:0]);

  always_comb begin
    wdata_lanes = wdata;
    case (funct3[1:0])
      2'b00:   wdata_lanes = {4{wdata[7:0]}};
      2'b01:   wdata_lanes = {2{wdata[15:0]}};
      default: wdata_lanes = wdata;
    endcase
  end

  always_comb begin
    io_next = io_output_bus;
    for (int b = 0; b < IO_WIDTH; b++) begin
      if (be[b/8]) io_next[b] = wdata_lanes[b];
    end
  end

  byte_lane_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clock (clock),
    .addr  (addr[AW+1:2]),
    .be    ((store_ok && region == REG_RAM) ? be : 4'b0000),
    .wdata (wdata_lanes),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= io_input_bus;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                                     io_output_bus <= '0;
    else if (store_ok && region == REG_IO_OUT)     io_output_bus <= io_next;
  end

  always_ff @(posedge clock) begin
    if (reset)                                     cycle_cnt <= '0;
    else if (store_ok && region == REG_CYCLE)      cycle_cnt <= '0;
    else                                           cycle_cnt <= cycle_cnt + 32'd1;
  end

  // MMIO values are snapshotted at the EX edge so a load sees pre-update state.
  always_comb begin
    mmio_word = '0;
    case (region)
      REG_IO_IN:  mmio_word = 32'(sync_q[SYNC_STAGES-1]);
      REG_IO_OUT: mmio_word = 32'(io_output_bus);
      REG_CYCLE:  mmio_word = cycle_cnt;
      default:    mmio_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_q     <= 1'b0;
      misaligned <= 1'b0;
      ram_sel_q  <= 1'b0;
      off_q      <= '0;
      f3_q       <= '0;
      mmio_q     <= '0;
    end else begin
      load_q     <= load_ok;
      misaligned <= (rd_en || wr_en) && misalign_raw;
      ram_sel_q  <= (region == REG_RAM);
      off_q      <= addr[1:0];
      f3_q       <= funct3;
      mmio_q     <= mmio_word;
    end
  end

  logic [31:0] raw_word;
  logic [31:0] shifted;
  logic [31:0] extended;

  always_comb begin
    raw_word = ram_sel_q ? ram_rdata : mmio_q;
    shifted  = raw_word >> {off_q, 3'b000};
    extended = shifted;
    case (f3_q)
      F3_B:    extended = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   extended = {24'h0, shifted[7:0]};
      F3_H:    extended = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   extended = {16'h0, shifted[15:0]};
      default: extended = shifted;
    endcase
    rdata = load_q ? extended : 32'h0;
  end

endmodule

// File: tb/tb_data_bus_unit.sv
// tb/tb_data_bus_unit.sv - self-checking bench for data_bus_unit
module tb_data_bus_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        rd_en, wr_en;
  logic [31:0] rdata;
  logic        misaligned;
  logic [10:0] io_input_bus;
  logic [10:0] io_output_bus;

  int tests = 0;
  int fails = 0;

  data_bus_unit #(.RAM_WORDS(256), .IO_WIDTH(11), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .addr          (addr),
    .wdata         (wdata),
    .funct3        (funct3),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .rdata         (rdata),
    .misaligned    (misaligned),
    .io_input_bus  (io_input_bus),
    .io_output_bus (io_output_bus)
  );

  always #5 clock = ~clock;

  // Reference model: byte-addressed memory and plain MMIO state.
  logic [7:0]  m_mem [1024];
  logic [10:0] m_io_out;
  logic [31:0] m_cycle;
  logic [10:0] m_sync0, m_sync1;
  logic [31:0] exp_rdata;
  logic        exp_mis;
  logic [10:0] exp_io;

  function automatic int access_size(input logic [2:0] f3);
    if (f3 == LB || f3 == LBU) return 1;
    if (f3 == LH || f3 == LHU) return 2;
    return 4;
  endfunction

  task automatic m_step(input bit rst, input int a, input logic [31:0] wd, input logic [2:0] f3,
                        input bit rd, input bit wr, input logic [10:0] io_in);
    int sz, base, off;
    bit mis, clr;
    logic [31:0] word, v;
    sz   = access_size(f3);
    mis  = (rd || wr) && (a % sz != 0);
    base = a - (a % 4);
    off  = a % 4;
    word = 0;
    clr  = 0;
    if (a < 1024)                 word = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    else if (base == 12'h400)     word = {21'h0, m_sync1};
    else if (base == 12'h404)     word = {21'h0, m_io_out};
    else if (base == 12'h408)     word = m_cycle;
    exp_rdata = 0;
    if (rst) begin
      exp_mis = 0; m_io_out = 0; m_cycle = 0; m_sync0 = 0; m_sync1 = 0; exp_io = 0;
      return;
    end
    if (rd && !wr && !mis) begin
      v = word >> (8 * off);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (f3 == LB && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (f3 == LH && v[15]) v = v | 32'hFFFF0000;
      end
      exp_rdata = v;
    end
    if (wr && !mis) begin
      for (int k = 0; k < sz; k++) begin
        int ba;
        logic [31:0] byt, full;
        ba   = a + k;
        byt  = (wd >> (8 * k)) & 32'hFF;
        if (ba < 1024) m_mem[ba] = byt[7:0];
        else if (base == 12'h404) begin
          full = {21'h0, m_io_out};
          full = (full & ~(32'hFF << (8 * (ba % 4)))) | (byt << (8 * (ba % 4)));
          m_io_out = full[10:0];
        end else if (base == 12'h408) clr = 1;
      end
    end
    m_cycle = clr ? 32'h0 : m_cycle + 1;
    m_sync1 = m_sync0;
    m_sync0 = io_in;
    exp_mis = mis;
    exp_io  = m_io_out;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step(input bit rst, input logic [11:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input bit rd, input bit wr);
    reset = rst; addr = a; wdata = wd; funct3 = f3; rd_en = rd; wr_en = wr;
    m_step(rst, int'(a), wd, f3, rd, wr, io_input_bus);
    @(posedge clock);
    @(negedge clock);
    check("model rdata", rdata, exp_rdata);
    check("model misaligned", 32'(misaligned), 32'(exp_mis));
    check("model io_out", 32'(io_output_bus), 32'(exp_io));
  endtask

  typedef struct {
    logic [11:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    bit          rd;
    bit          wr;
    logic [31:0] er;
    bit          em;
    logic [10:0] eio;
  } vec_t;

  vec_t vecs[31];

  initial begin
    vecs[0]  = '{12'h010, 32'h80FF7F01, LW,     0, 1, 32'h00000000, 0, 11'h000};
    vecs[1]  = '{12'h013, 32'h0,        LB,     1, 0, 32'hFFFFFF80, 0, 11'h000};
    vecs[2]  = '{12'h013, 32'h0,        LBU,    1, 0, 32'h00000080, 0, 11'h000};
    vecs[3]  = '{12'h010, 32'h0,        LB,     1, 0, 32'h00000001, 0, 11'h000};
    vecs[4]  = '{12'h012, 32'h0,        LH,     1, 0, 32'hFFFF80FF, 0, 11'h000};
    vecs[5]  = '{12'h010, 32'h0,        LHU,    1, 0, 32'h00007F01, 0, 11'h000};
    vecs[6]  = '{12'h020, 32'h0,        LW,     0, 1, 32'h00000000, 0, 11'h000};
    vecs[7]  = '{12'h022, 32'h1234BEEF, LH,     0, 1, 32'h00000000, 0, 11'h000};
    vecs[8]  = '{12'h020, 32'h0,        LW,     1, 0, 32'hBEEF0000, 0, 11'h000};
    vecs[9]  = '{12'h022, 32'h0,        LH,     1, 0, 32'hFFFFBEEF, 0, 11'h000};
    vecs[10] = '{12'h021, 32'h0000AAAA, LH,     0, 1, 32'h00000000, 1, 11'h000};
    vecs[11] = '{12'h021, 32'h0,        LH,     0, 0, 32'h00000000, 0, 11'h000};
    vecs[12] = '{12'h020, 32'h0,        LW,     1, 0, 32'hBEEF0000, 0, 11'h000};
    vecs[13] = '{12'h021, 32'h0,        LW,     1, 0, 32'h00000000, 1, 11'h000};
    vecs[14] = '{12'h404, 32'h000007FF, LW,     0, 1, 32'h00000000, 0, 11'h7FF};
    vecs[15] = '{12'h404, 32'h00000000, LB,     0, 1, 32'h00000000, 0, 11'h700};
    vecs[16] = '{12'h404, 32'h0,        LW,     1, 0, 32'h00000700, 0, 11'h700};
    vecs[17] = '{12'h405, 32'h0,        LBU,    1, 0, 32'h00000007, 0, 11'h700};
    vecs[18] = '{12'h40C, 32'hFFFFFFFF, LW,     0, 1, 32'h00000000, 0, 11'h700};
    vecs[19] = '{12'h40C, 32'h0,        LW,     1, 0, 32'h00000000, 0, 11'h700};
    vecs[20] = '{12'h800, 32'h0,        LW,     1, 0, 32'h00000000, 0, 11'h700};
    vecs[21] = '{12'h010, 32'h0,        3'b011, 1, 0, 32'h80FF7F01, 0, 11'h700};
    vecs[22] = '{12'h404, 32'h00000123, LW,     1, 1, 32'h00000000, 0, 11'h123};
    vecs[23] = '{12'h404, 32'h0,        LW,     1, 0, 32'h00000123, 0, 11'h123};
    vecs[24] = '{12'h406, 32'h00000055, LB,     0, 1, 32'h00000000, 0, 11'h123};
    vecs[25] = '{12'h400, 32'h000003FF, LW,     0, 1, 32'h00000000, 0, 11'h123};
    vecs[26] = '{12'h400, 32'h0,        LW,     1, 0, 32'h00000000, 0, 11'h123};
    vecs[27] = '{12'h010, 32'h0,        3'b110, 1, 0, 32'h80FF7F01, 0, 11'h123};
    vecs[28] = '{12'h404, 32'h00000456, 3'b111, 0, 1, 32'h00000000, 0, 11'h456};
    vecs[29] = '{12'h013, 32'h0,        LH,     1, 0, 32'h00000000, 1, 11'h456};
    vecs[30] = '{12'h402, 32'h0,        LHU,    1, 0, 32'h00000000, 0, 11'h456};

    reset = 1; addr = 0; wdata = 0; funct3 = 0; rd_en = 0; wr_en = 0; io_input_bus = 0;
    m_io_out = 0; m_cycle = 0; m_sync0 = 0; m_sync1 = 0;
    @(negedge clock);
    step(1, 12'h0, 32'h0, LW, 0, 0);
    step(1, 12'h0, 32'h0, LW, 0, 0);
    check("reset rdata", rdata, 32'h0);
    check("reset misaligned", 32'(misaligned), 32'h0);
    check("reset io_out", 32'(io_output_bus), 32'h0);

    for (int w = 0; w < 256; w++) step(0, 12'(w * 4), $urandom, LW, 0, 1);

    for (int i = 0; i < 31; i++) begin
      step(0, vecs[i].a, vecs[i].wd, vecs[i].f3, vecs[i].rd, vecs[i].wr);
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].er);
      check($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(vecs[i].em));
      check($sformatf("vec%0d io_out", i), 32'(io_output_bus), 32'(vecs[i].eio));
    end

    // Input synchronizer latency.
    io_input_bus = 11'h155;
    step(0, 12'h0, 32'h0, LW, 0, 0);
    step(0, 12'h400, 32'h0, LW, 1, 0);
    check("sync one edge", rdata, 32'h0);
    io_input_bus = 11'h0;
    for (int i = 0; i < 3; i++) step(0, 12'h0, 32'h0, LW, 0, 0);
    io_input_bus = 11'h155;
    step(0, 12'h0, 32'h0, LW, 0, 0);
    step(0, 12'h0, 32'h0, LW, 0, 0);
    step(0, 12'h400, 32'h0, LW, 1, 0);
    check("sync two edges", rdata, 32'h00000155);

    // Cycle counter clear and count.
    step(0, 12'h408, 32'h0, LW, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 12'h0, 32'h0, LW, 0, 0);
    step(0, 12'h408, 32'h0, LW, 1, 0);
    check("cycle after 10", rdata, 32'd10);

    // Cycle counter wrap via backdoor.
    rd_en = 0; wr_en = 0;
    m_step(0, 0, 32'h0, LW, 0, 0, io_input_bus);
    force dut.cycle_cnt = 32'hFFFFFFFF;
    @(posedge clock);
    @(negedge clock);
    release dut.cycle_cnt;
    m_cycle = 32'hFFFFFFFF;
    step(0, 12'h408, 32'h0, LW, 1, 0);
    check("cycle max", rdata, 32'hFFFFFFFF);
    step(0, 12'h408, 32'h0, LW, 1, 0);
    check("cycle wrap", rdata, 32'h0);

    // Reset in the middle of traffic.
    step(0, 12'h404, 32'h000007FF, LW, 0, 1);
    step(1, 12'h404, 32'h000003AB, LW, 0, 1);
    check("reset store io_out", 32'(io_output_bus), 32'h0);
    check("reset store rdata", rdata, 32'h0);
    step(1, 12'h010, 32'h0, LW, 1, 0);
    check("reset load rdata", rdata, 32'h0);
    step(0, 12'h408, 32'h0, LW, 1, 0);
    check("cycle after reset", rdata, 32'h0);
    step(0, 12'h010, 32'h0, LW, 1, 0);
    check("ram kept over reset", rdata, 32'h80FF7F01);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      int sel;
      logic [11:0] a;
      logic [2:0]  f3;
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = 12'($urandom_range(0, 12'h3FF));
      else if (sel < 9) a = 12'(12'h400 + $urandom_range(0, 15));
      else              a = 12'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a = 12'(a - (a % access_size(f3)));
      if ($urandom_range(0, 3) == 0) io_input_bus = 11'($urandom);
      step($urandom_range(0, 49) == 0, a, $urandom, f3, 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_bus_unit.md
# data_bus_unit

Memory-stage data bus for the RV32I pipeline: it takes the EX-stage effective address, store data and access type, and performs RAM or memory-mapped I/O accesses. It returns the sign- or zero-extended load result one cycle later, in the MEM stage. It holds 1 KiB of byte-lane data RAM, a synchronized input port, a registered output port and a free-running cycle counter. The core's forwarding and write-back paths consume `rdata` directly.

## Interface
- `RAM_WORDS`, 256: data RAM depth in 32-bit words (byte range 0x000–0x3FF).
- `IO_WIDTH`, 11: width of the I/O buses.
- `SYNC_STAGES`, 2: flop stages on `io_input_bus`.
- `clock` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-high.
- `addr` in 12: byte address (EX ALU out).
- `wdata` in 32: raw rs2 store data.
- `funct3` in 3: access type: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- `rd_en` in 1: load in EX this cycle.
- `wr_en` in 1: store in EX this cycle.
- `rdata` out 32: extended load data, valid the cycle after `rd_en`.
- `misaligned` out 1: one-cycle flag, asserted the cycle after a misaligned access.
- `io_input_bus` in `IO_WIDTH`: external input, asynchronous.
- `io_output_bus` out `IO_WIDTH`: registered output port.

## Operation
- Address map:
  - 0x000–0x3FF: RAM.
  - 0x400 IO_IN: read-only; writes are ignored.
  - 0x404 IO_OUT: read/write.
  - 0x408 CYCLE: read returns the count; any store clears it.
  - 0x40C–0xFFF: reads return 0; writes are ignored.
- Alignment rules:
  - Halfword access requires `addr[0]=0`.
  - Word access requires `addr[1:0]=0`.
  - A misaligned store writes nothing.
  - A misaligned load returns 0.
  - Both cases set `misaligned` for one cycle.
- Store byte lanes:
  - sb writes lane `addr[1:0]` with `wdata[7:0]`.
  - sh writes lanes {`addr[1]`*2, +1} with `wdata[15:0]`.
  - sw writes all four lanes.
  - IO_OUT honours the same lanes on its low `IO_WIDTH` bits; the remaining bits are ignored.
- Load extraction in MEM uses registered `addr[1:0]` and `funct3`:
  - lb/lh sign-extend.
  - lbu/lhu zero-extend.
  - lw passes the word through.
  - IO_IN and IO_OUT are zero-extended to 32 bits before lane selection.
- `rd_en` and `wr_en` both high is illegal; the unit treats it as a store.
- Undefined `funct3` codes (011, 110, 111) behave as lw/sw.
- CYCLE increments every cycle and wraps 0xFFFFFFFF→0. A store to CYCLE forces 0 on that edge. A load returns the value held at the EX edge.
- IO_IN reads return the last synchronizer stage.
- `rdata` is 0 in any cycle not following a `rd_en`.

## Timing
- Reset (synchronous): `rdata`, `misaligned`, `io_output_bus`, CYCLE and the synchronizer all go to 0. A store asserted with `reset` is suppressed. RAM contents are not reset.
- Load latency is one cycle: `rd_en` at edge N → `rdata` valid after edge N until edge N+1.
- Stores commit at the edge where `wr_en` is sampled. `io_output_bus` changes immediately after that edge.
- Store to word W at edge N, then load of W at edge N+1 → the load returns the new data. No bypass is needed because the RAM reads synchronously after the write.
- Input latency: a change on `io_input_bus` is readable `SYNC_STAGES` edges later.
- Back-to-back loads are sustained every cycle.
- There is no stall or handshake; the unit always accepts.

## Structure
- Package `data_bus_pkg`:
  - address-map constants (`ADDR_IO_IN`, `ADDR_IO_OUT`, `ADDR_CYCLE`, `RAM_TOP`);
  - funct3 codes (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- Sub-module `byte_lane_ram`: `RAM_WORDS`×32 storage with a 4-bit byte-enable write and a registered synchronous read. It is written so it infers block RAM.
- Top level contains:
  - decode;
  - lane and alignment logic;
  - MEM-stage registers (offset, funct3, region select, misaligned);
  - the output-select mux;
  - IO_OUT, CYCLE and the synchronizer.

## Test plan
- Byte loads: sw 0x80FF7F01 @0x010, then lb @0x013 → 0xFFFFFF80; lbu @0x013 → 0x00000080; lb @0x010 → 0x00000001.
- Halfword store and alignment: sh 0xBEEF @0x022 over word 0 → word reads 0xBEEF0000.
  - lh @0x022 → 0xFFFFBEEF.
  - sh @0x021 → no write, `misaligned`=1 for exactly one cycle, word unchanged.
- MMIO output: sw 0x7FF @0x404 → `io_output_bus`=0x7FF next cycle. sb 0x00 @0x404 → 0x700. Load @0x404 → 0x00000700.
- Input synchronizer: set `io_input_bus`=0x155. A load @0x400 issued 1 edge after the change returns 0; issued 2 edges after, it returns 0x00000155.
- Cycle counter: preload via a store clear, run 10 cycles, load → 10. Force the counter to 0xFFFFFFFF (backdoor) → wraps to 0.
- Reset mid-operation: assert `reset` together with a sw to 0x404 → `io_output_bus` stays 0, `rdata`=0. RAM data written before reset still reads back after reset.
